spike_volley_encoder: RTL and testbench



---
 rtl/spike_volley_encoder_if.sv | 42 ++++
 rtl/spike_volley_encoder.sv | 138 +++++++++++++
 tb/tb_spike_volley_encoder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_volley_encoder_if.sv
// -----------------------------------------------------------------------------
// spike_volley_encoder_if
//   Bundles the input-vector handshake, the stop request from the
//   winner-take-all stage and the per-time-step volley outputs of
//   spike_volley_encoder.
//
//   Signals:
//     in_valid      producer -> encoder  input vector offered
//     in_ready      encoder  -> producer encoder can accept a vector
//     in_data       producer -> encoder  N lanes of VAL_W-bit intensities
//     stop          consumer -> encoder  winner found, terminate window
//     time_val      encoder  -> consumer current time step (TIME_W+1 bits)
//     spike_volley  encoder  -> consumer one bit per line for this time step
//     volley_valid  encoder  -> consumer time_val/spike_volley are in-window
//     done          encoder  -> consumer one-cycle end-of-window pulse
//
//   Modports: master = the producer/consumer environment, slave = encoder.
// -----------------------------------------------------------------------------
interface spike_volley_encoder_if #(
  parameter int N      = 16,
  parameter int VAL_W  = 3,
  parameter int TIME_W = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N*VAL_W-1:0]   in_data;
  logic                 stop;
  logic [TIME_W:0]      time_val;
  logic [N-1:0]         spike_volley;
  logic                 volley_valid;
  logic                 done;

  modport master (
    output in_valid, in_data, stop,
    input  in_ready, time_val, spike_volley, volley_valid, done
  );

  modport slave (
    input  in_valid, in_data, stop,
    output in_ready, time_val, spike_volley, volley_valid, done
  );
endinterface

// File: rtl/spike_volley_encoder.sv
// -----------------------------------------------------------------------------
// spike_volley_encoder
//   Time-to-first-spike encoder feeding the lateral-inhibition stage. One
//   vector of N intensities is accepted, then a counter sweeps one window of
//   TIME_PERIOD steps; lane i spikes in the single step equal to its latched
//   spike time. A stop from downstream ends the window early.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   spike_volley_encoder_if.slave (handshake, stop, volley outputs)
//
//   Build option:
//     SPIKE_INVERT_INTENSITY_EN  when defined, spike time = (2^VAL_W-1) - lane
//                                value so brighter inputs spike earlier;
//                                otherwise spike time = lane value.
//
//   All outputs are registered: the combinational output logic computes the
//   values for the state being entered, so the first volley (time_val = 0)
//   appears the cycle after the accepting edge.
// -----------------------------------------------------------------------------
module spike_volley_encoder #(
  parameter int N           = 16,
  parameter int VAL_W       = 3,
  parameter int TIME_PERIOD = 8,
  parameter int TIME_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  spike_volley_encoder_if.slave bus
);

  localparam int CNT_W = TIME_W + 1;
  // Compare width wide enough for both operands so neither side truncates.
  localparam int CMP_W = (VAL_W > CNT_W) ? VAL_W : CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(TIME_PERIOD - 1);
  localparam logic [CNT_W-1:0] PERIOD_CODE = CNT_W'(TIME_PERIOD);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N*VAL_W-1:0]   t_q, t_d;

  logic                 in_ready_q, in_ready_d;
  logic [CNT_W-1:0]     time_val_q, time_val_d;
  logic [N-1:0]         spike_q, spike_d;
  logic                 volley_valid_q, volley_valid_d;
  logic                 done_q, done_d;

  // Per-lane (2^VAL_W-1) - x equals the bitwise complement of x, so the
  // whole packed vector can be inverted at once.
  function automatic logic [N*VAL_W-1:0] encode(input logic [N*VAL_W-1:0] raw);
`ifdef SPIKE_INVERT_INTENSITY_EN
    return ~raw;
`else
    return raw;
`endif
  endfunction

  // State register, counter, latched spike times and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      // NOTE: the spike-time bank is a small register set, not a RAM, and
      // its value is observable, so it is reset like any other state.
      t_q            <= '1;
      in_ready_q     <= 1'b1;
      time_val_q     <= PERIOD_CODE;
      spike_q        <= '0;
      volley_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      t_q            <= t_d;
      in_ready_q     <= in_ready_d;
      time_val_q     <= time_val_d;
      spike_q        <= spike_d;
      volley_valid_q <= volley_valid_d;
      done_q         <= done_d;
    end
  end

  // Next-state logic. in_ready is high exactly in IDLE, so an accept is
  // in_valid seen while in IDLE; stop and in_valid are ignored elsewhere.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          t_d     = encode(bus.in_data);
        end
      end
      RUN: begin
        if (bus.stop || (cnt_q == LAST_CNT)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: values presented while in the state being entered.
  always_comb begin
    in_ready_d     = (state_d == IDLE);
    volley_valid_d = (state_d == RUN);
    done_d         = (state_d == DONE);
    time_val_d     = (state_d == RUN) ? cnt_d : PERIOD_CODE;
    spike_d        = '0;
    if (state_d == RUN) begin
      // Zero-extended compare: a time code >= TIME_PERIOD is never reached
      // by the counter, so that lane stays silent for the whole window.
      for (int i = 0; i < N; i++) begin
        spike_d[i] = (CMP_W'(t_d[i*VAL_W +: VAL_W]) == CMP_W'(cnt_d));
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.time_val     = time_val_q;
  assign bus.spike_volley = spike_q;
  assign bus.volley_valid = volley_valid_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_spike_volley_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_volley_encoder
//   Directed, table-driven bench for spike_volley_encoder (defaults N=16,
//   VAL_W=3, TIME_PERIOD=8) plus a small second instance (N=4,
//   TIME_PERIOD=5) where some lane codes fall outside the window. Expected
//   volleys are hand-computed for both settings of SPIKE_INVERT_INTENSITY_EN.
// -----------------------------------------------------------------------------
module tb_spike_volley_encoder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spike_volley_encoder_if #(.N(16), .VAL_W(3), .TIME_W(3)) bus ();
  spike_volley_encoder_if #(.N(4),  .VAL_W(3), .TIME_W(3)) bus2 ();

  spike_volley_encoder #(.N(16), .VAL_W(3), .TIME_PERIOD(8), .TIME_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spike_volley_encoder #(.N(4), .VAL_W(3), .TIME_PERIOD(5), .TIME_W(3)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic [47:0] data;
    int          stop_at;   // time step at which stop is raised, -1 = never
    logic [15:0] exp [8];   // expected spike_volley per time step
    int          exp_len;   // number of volley_valid cycles expected
  } vec_t;

  vec_t vecs [4];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [47:0] with_lane(input logic [47:0] d, input int i,
                                            input logic [2:0] v);
    logic [47:0] r;
    r = d;
    r[i*3 +: 3] = v;
    return r;
  endfunction

  // Returns at a falling edge with the DUT idle, or records a timeout.
  task automatic wait_idle(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1 && bus.done === 1'b0) found = 1'b1;
    end
    if (!found) check({name, "_idle_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    logic [47:0] mod8;
    logic [15:0] lane_cnt_hit;
    logic [15:0] lane_multi;
    int          total_spikes;
    int          first_t, second_t;
    bit          seen_done;
    logic [15:0] e2 [5];

    // ---------------- table -------------------------------------------------
    mod8 = '0;
    for (int i = 0; i < 16; i++) mod8 = with_lane(mod8, i, 3'(i % 8));
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 8; k++) vecs[v].exp[k] = '0;
      vecs[v].stop_at = -1;
      vecs[v].exp_len = 8;
    end
    // V0: lane0=0, lane5=3, others 7
    vecs[0].data = with_lane(with_lane({48{1'b1}}, 0, 3'd0), 5, 3'd3);
    // V1: lane i = i mod 8 (every lane in window)
    vecs[1].data = mod8;
    // V2: same vector, stop raised while time_val = 2
    vecs[2].data    = mod8;
    vecs[2].stop_at = 2;
    vecs[2].exp_len = 3;
    // V3: lane2=7, lane3=0, others 7
    vecs[3].data = with_lane(with_lane({48{1'b1}}, 2, 3'd7), 3, 3'd0);
`ifdef SPIKE_INVERT_INTENSITY_EN
    vecs[0].exp[0] = 16'hFFDE; vecs[0].exp[4] = 16'h0020; vecs[0].exp[7] = 16'h0001;
    for (int k = 0; k < 8; k++) vecs[1].exp[k] = 16'h0101 << (7 - k);
    vecs[2].exp[0] = 16'h8080; vecs[2].exp[1] = 16'h4040; vecs[2].exp[2] = 16'h2020;
    vecs[3].exp[0] = 16'hFFF7; vecs[3].exp[7] = 16'h0008;
    e2[0] = 4'h8; e2[1] = 4'h0; e2[2] = 4'h4; e2[3] = 4'h2; e2[4] = 4'h0;
`else
    vecs[0].exp[0] = 16'h0001; vecs[0].exp[3] = 16'h0020; vecs[0].exp[7] = 16'hFFDE;
    for (int k = 0; k < 8; k++) vecs[1].exp[k] = 16'h0101 << k;
    vecs[2].exp[0] = 16'h0101; vecs[2].exp[1] = 16'h0202; vecs[2].exp[2] = 16'h0404;
    vecs[3].exp[0] = 16'h0008; vecs[3].exp[7] = 16'hFFF7;
    e2[0] = 4'h1; e2[1] = 4'h0; e2[2] = 4'h0; e2[3] = 4'h0; e2[4] = 4'h2;
`endif

    // ---------------- reset -------------------------------------------------
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.stop = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.stop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",     64'(bus.in_ready),     64'(1));
    check("rst_time_val",     64'(bus.time_val),     64'(8));
    check("rst_spike",        64'(bus.spike_volley), 64'(0));
    check("rst_volley_valid", 64'(bus.volley_valid), 64'(0));
    check("rst_done",         64'(bus.done),         64'(0));

    // stop while idle must be ignored
    bus.stop = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_stop_ready", 64'(bus.in_ready),     64'(1));
    check("idle_stop_valid", 64'(bus.volley_valid), 64'(0));
    bus.stop = 1'b0;

    // ---------------- table-driven windows ----------------------------------
    for (int v = 0; v < 4; v++) begin
      wait_idle($sformatf("v%0d", v));
      bus.in_data  = vecs[v].data;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 48'($urandom) ^ {$urandom, 16'h0};  // must not matter now
      lane_cnt_hit = '0;
      lane_multi   = '0;
      total_spikes = 0;
      for (int k = 0; k < vecs[v].exp_len; k++) begin
        @(negedge clk);
        check($sformatf("v%0d_t%0d_time_val", v, k), 64'(bus.time_val), 64'(k));
        check($sformatf("v%0d_t%0d_valid", v, k), 64'(bus.volley_valid), 64'(1));
        check($sformatf("v%0d_t%0d_ready", v, k), 64'(bus.in_ready), 64'(0));
        check($sformatf("v%0d_t%0d_spike", v, k), 64'(bus.spike_volley),
              64'(vecs[v].exp[k]));
        lane_multi   = lane_multi | (lane_cnt_hit & bus.spike_volley);
        lane_cnt_hit = lane_cnt_hit | bus.spike_volley;
        total_spikes += $countones(bus.spike_volley);
        if (k == vecs[v].stop_at) bus.stop = 1'b1;
      end
      @(negedge clk);
      bus.stop = 1'b0;
      check($sformatf("v%0d_done", v),       64'(bus.done),         64'(1));
      check($sformatf("v%0d_done_valid", v), 64'(bus.volley_valid), 64'(0));
      check($sformatf("v%0d_done_spike", v), 64'(bus.spike_volley), 64'(0));
      check($sformatf("v%0d_done_time", v),  64'(bus.time_val),     64'(8));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), 64'(bus.done),     64'(0));
      check($sformatf("v%0d_idle_ready", v), 64'(bus.in_ready), 64'(1));
      if (v == 1) begin
        check("v1_total_spikes", 64'(total_spikes), 64'(16));
        check("v1_lane_multi",   64'(lane_multi),   64'(0));
        check("v1_lane_all",     64'(lane_cnt_hit), 64'(16'hFFFF));
      end
    end

    // ---------------- back-to-back with in_valid held high ------------------
    wait_idle("b2b");
    bus.in_data  = vecs[0].data;
    bus.in_valid = 1'b1;
    first_t  = -1;
    second_t = -1;
    for (int c = 0; c < 40 && second_t < 0; c++) begin
      @(negedge clk);
      if (bus.volley_valid === 1'b1 && bus.time_val === 4'd0) begin
        if (first_t < 0) first_t = c;
        else             second_t = c;
      end
      if (first_t >= 0 && second_t < 0 && (c - first_t) < 8)
        check($sformatf("b2b_t%0d_spike", c - first_t), 64'(bus.spike_volley),
              64'(vecs[0].exp[c - first_t]));
      if (first_t >= 0) bus.in_data = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    end
    bus.in_valid = 1'b0;
    check("b2b_spacing", 64'(second_t - first_t), 64'(10));

    // ---------------- asynchronous reset mid-window -------------------------
    wait_idle("rst_mid");
    bus.in_data  = vecs[1].data;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("amid_in_ready",     64'(bus.in_ready),     64'(1));
    check("amid_time_val",     64'(bus.time_val),     64'(8));
    check("amid_spike",        64'(bus.spike_volley), 64'(0));
    check("amid_volley_valid", 64'(bus.volley_valid), 64'(0));
    check("amid_done",         64'(bus.done),         64'(0));
    #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.volley_valid !== 1'b0) seen_done = 1'b1;
    end
    check("amid_no_partial_done", 64'(seen_done), 64'(0));

    // ---------------- short window, out-of-window codes ---------------------
    // lanes: 0 -> 0, 1 -> 4, 2 -> 5, 3 -> 7 with TIME_PERIOD = 5
    @(negedge clk);
    check("s_idle_time", 64'(bus2.time_val), 64'(5));
    bus2.in_data  = {3'd7, 3'd5, 3'd4, 3'd0};
    bus2.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("s_t%0d_time_val", k), 64'(bus2.time_val), 64'(k));
      check($sformatf("s_t%0d_valid", k), 64'(bus2.volley_valid), 64'(1));
      check($sformatf("s_t%0d_spike", k), 64'(bus2.spike_volley), 64'(e2[k]));
    end
    @(negedge clk);
    check("s_done",      64'(bus2.done),         64'(1));
    check("s_done_time", 64'(bus2.time_val),     64'(5));
    check("s_done_spk",  64'(bus2.spike_volley), 64'(0));
    @(negedge clk);
    check("s_idle_ready", 64'(bus2.in_ready), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
